// File: rtl/display_pkg.sv
// Shared command-field constants, init ROM and FSM state encoding for the display sequencer.
package display_pkg;

  localparam int CMD_W       = 11;
  localparam int CMD_SEL     = 10;
  localparam int CMD_RS      = 9;
  localparam int CMD_RW      = 8;
  localparam int CMD_BYTE_HI = 7;
  localparam int CMD_BYTE_LO = 0;

  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME  = 8'h02;

  localparam int INIT_LEN  = 5;
  localparam int ROM_IDX_W = 3;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_HOLD,
    S_IDLE,
    S_ISSUE
  } state_e;

  function automatic logic [CMD_W-1:0] init_rom(input logic [ROM_IDX_W-1:0] idx);
    case (idx)
      3'd0, 3'd1: init_rom = 11'h038;
      3'd2:       init_rom = 11'h00C;
      3'd3:       init_rom = 11'h001;
      3'd4:       init_rom = 11'h006;
      default:    init_rom = '0;
    endcase
  endfunction

  // Only instruction-register writes of clear/home need the long display settle time.
  function automatic logic is_clr_home(input logic [CMD_W-1:0] cmd);
    return !cmd[CMD_SEL] && !cmd[CMD_RS] && !cmd[CMD_RW] &&
           (cmd[CMD_BYTE_HI:CMD_BYTE_LO] == CLEAR || cmd[CMD_BYTE_HI:CMD_BYTE_LO] == HOME);
  endfunction

endpackage

// File: rtl/display_seq_arb.sv
// Combinational NREQ-way picker: round-robin from ptr, or lowest-index-wins when
// DISPLAY_SEQ_FIXED_PRIO_EN is defined (the ptr port then disappears).
module display_seq_arb #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
`ifndef DISPLAY_SEQ_FIXED_PRIO_EN
  input  logic [PW-1:0]   ptr,
`endif
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);

  logic          found;
  logic [PW-1:0] k;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef DISPLAY_SEQ_FIXED_PRIO_EN
      k = PW'(i);
`else
      k = PW'((int'(ptr) + i) % NREQ);
`endif
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Init-ROM player and requester arbiter feeding the LCD command port, one word in flight.
// Build option: DISPLAY_SEQ_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module display_sequencer
  import display_pkg::*;
#(
  parameter int CLOCK    = 25000,
  parameter int NREQ     = 2,
  parameter int PWRUP_MS = 40,
  parameter int CLR_MS   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*CMD_W-1:0]  i_req_cmd,
  output logic [NREQ-1:0]        o_grant,
  output logic [CMD_W-1:0]       o_command,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_init_done
);

  localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PWRUP_CYC = CLOCK * PWRUP_MS / 1000;
  localparam int CLR_CYC   = CLOCK * CLR_MS / 1000;
  localparam int MAX_CYC   = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int TW        = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

  localparam logic [TW-1:0]        PWRUP_LAST = TW'((PWRUP_CYC > 0) ? PWRUP_CYC - 1 : 0);
  localparam logic [TW-1:0]        CLR_LAST   = TW'((CLR_CYC > 0) ? CLR_CYC - 1 : 0);
  localparam logic [ROM_IDX_W-1:0] ROM_LAST   = ROM_IDX_W'(INIT_LEN - 1);

  state_e                 state_q, state_d, ret_q, ret_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [ROM_IDX_W-1:0]   rom_idx_q, rom_idx_d;
  logic [CMD_W-1:0]       cmd_q, cmd_d;
  logic                   valid_q, valid_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic                   done_q, done_d;

  logic [NREQ-1:0]        win_grant;
  logic [PW-1:0]          win_idx;
  logic [CMD_W-1:0]       req_cmd [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_cmd
    assign req_cmd[g] = i_req_cmd[g*CMD_W +: CMD_W];
  end

`ifdef DISPLAY_SEQ_FIXED_PRIO_EN
  display_seq_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (i_req),
    .grant (win_grant),
    .idx   (win_idx)
  );
`else
  logic [PW-1:0] ptr_q, ptr_d;

  display_seq_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (win_grant),
    .idx   (win_idx)
  );
`endif

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    timer_d   = '0;
    rom_idx_d = rom_idx_q;
    cmd_d     = cmd_q;
    valid_d   = valid_q;
    grant_d   = '0;
    done_d    = done_q;
`ifndef DISPLAY_SEQ_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    // The timer idles at zero outside the wait states, so every wait starts from a fresh count.
    case (state_q)
      S_PWRUP: begin
        if (timer_q == PWRUP_LAST) begin
          state_d   = S_INIT;
          rom_idx_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_INIT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          cmd_d   = init_rom(rom_idx_q);
        end else if (i_ready) begin
          valid_d   = 1'b0;
          rom_idx_d = rom_idx_q + 1'b1;
          ret_d     = S_INIT;
          if (rom_idx_q == ROM_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            ret_d   = S_IDLE;
          end
          if (is_clr_home(cmd_q)) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (timer_q == CLR_LAST) state_d = ret_q;
        else                     timer_d = timer_q + 1'b1;
      end
      S_IDLE: begin
        if (|i_req) begin
          cmd_d   = req_cmd[win_idx];
          valid_d = 1'b1;
          grant_d = win_grant;
          state_d = S_ISSUE;
`ifndef DISPLAY_SEQ_FIXED_PRIO_EN
          ptr_d   = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      S_ISSUE: begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          ret_d   = S_IDLE;
          state_d = is_clr_home(cmd_q) ? S_HOLD : S_IDLE;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_PWRUP;
      ret_q     <= S_INIT;
      timer_q   <= '0;
      rom_idx_q <= '0;
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      grant_q   <= '0;
      done_q    <= 1'b0;
`ifndef DISPLAY_SEQ_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      timer_q   <= timer_d;
      rom_idx_q <= rom_idx_d;
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
`ifndef DISPLAY_SEQ_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign o_command   = cmd_q;
  assign o_valid     = valid_q;
  assign o_grant     = grant_q;
  assign o_init_done = done_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer: directed vector table, hand sequences for
// the multi-cycle corners, then randomized traffic against a transaction-level model.
module tb_display_sequencer;

  localparam int NREQ = 2;
  localparam int W    = 11;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   req_cmd;
  logic                ready;
  logic [NREQ-1:0]     o_grant;
  logic [W-1:0]        o_command;
  logic                o_valid;
  logic                o_init_done;

  always #5 clk = ~clk;

  display_sequencer #(.CLOCK(25000), .NREQ(NREQ), .PWRUP_MS(40), .CLR_MS(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_req_cmd   (req_cmd),
    .o_grant     (o_grant),
    .o_command   (o_command),
    .o_valid     (o_valid),
    .i_ready     (ready),
    .o_init_done (o_init_done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] rom_exp [5] = '{11'h038, 11'h038, 11'h00C, 11'h001, 11'h006};

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] c0;
    logic [W-1:0] c1;
    logic [1:0]   g_rr;
    logic [1:0]   g_fp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [W-1:0] rand_cmd();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 11'h001;
    if (r == 1) return 11'h002;
    return W'($urandom & 32'h7FF);
  endfunction

  // Called at the negedge where reset has just been released.
  task automatic run_init(input string tag);
    logic [W-1:0] words[$];
    bit quiet;
    int t_clr, rise, first;
    req   = '0;
    ready = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (o_valid !== 1'b0) quiet = 1'b0;
    end
    check({tag, " pwrup quiet"}, 32'(quiet), 1);
    t_clr = -1; rise = -1; first = -1;
    for (int k = 0; k < 400 && o_init_done !== 1'b1; k++) begin
      step();
      if (o_valid === 1'b1) begin
        if (first < 0) first = k;
        if (t_clr >= 0 && rise < 0) rise = cyc;
        words.push_back(o_command);
        if (o_command == 11'h001) t_clr = cyc;
      end
    end
    check({tag, " first word prompt"}, 32'(first >= 0 && first <= 3), 1);
    check({tag, " init_done"}, 32'(o_init_done), 1);
    check({tag, " word count"}, 32'(words.size()), 5);
    for (int i = 0; i < 5 && i < words.size(); i++)
      check($sformatf("%s init word %0d", tag, i), 32'(words[i]), 32'(rom_exp[i]));
    check({tag, " clear gap >= 50"}, 32'(t_clr >= 0 && rise - t_clr >= 50), 1);
  endtask

  // Transaction-level model state for the random phase.
  bit           m_valid;
  logic [1:0]   m_grant;
  logic [W-1:0] m_cmd;
  int           m_ptr;
  int           m_idle_from;

  function automatic int model_pick(input logic [1:0] r);
`ifdef DISPLAY_SEQ_FIXED_PRIO_EN
    return r[0] ? 0 : 1;
`else
    if (r[m_ptr]) return m_ptr;
    return 1 - m_ptr;
`endif
  endfunction

  initial begin
    logic [1:0]   eg;
    logic [W-1:0] ec;
    logic [1:0]   gseq[$];
    bit           stable;
    int           g, rise, cnt, w;

    vecs[0] = '{2'b01, 11'h431, 11'h000, 2'b01, 2'b01};
    vecs[1] = '{2'b11, 11'h601, 11'h602, 2'b10, 2'b01};
    vecs[2] = '{2'b11, 11'h601, 11'h602, 2'b01, 2'b01};
    vecs[3] = '{2'b11, 11'h601, 11'h602, 2'b10, 2'b01};
    vecs[4] = '{2'b10, 11'h000, 11'h2A5, 2'b10, 2'b10};
    vecs[5] = '{2'b11, 11'h123, 11'h3FF, 2'b01, 2'b01};
    vecs[6] = '{2'b11, 11'h555, 11'h0AA, 2'b10, 2'b01};

    // T1: reset values and the power-up / init ROM sequence.
    rst = 1'b1; req = '0; req_cmd = '0; ready = 1'b0;
    repeat (3) step();
    check("reset valid", 32'(o_valid), 0);
    check("reset command", 32'(o_command), 0);
    check("reset grant", 32'(o_grant), 0);
    check("reset init_done", 32'(o_init_done), 0);
    rst = 1'b0;
    run_init("T1");

    // T2/T3 single-shot arbitration vectors from idle, i_ready high.
    ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
`ifdef DISPLAY_SEQ_FIXED_PRIO_EN
      eg = vecs[i].g_fp;
`else
      eg = vecs[i].g_rr;
`endif
      ec = eg[0] ? vecs[i].c0 : vecs[i].c1;
      req = vecs[i].req;
      req_cmd = {vecs[i].c1, vecs[i].c0};
      step();
      check($sformatf("vec%0d grant", i), 32'(o_grant), 32'(eg));
      check($sformatf("vec%0d valid", i), 32'(o_valid), 1);
      check($sformatf("vec%0d command", i), 32'(o_command), 32'(ec));
      req = '0;
      step();
      check($sformatf("vec%0d valid drop", i), 32'(o_valid), 0);
      check($sformatf("vec%0d grant pulse", i), 32'(o_grant), 0);
    end

    // T3: both requesters held high.
    req = 2'b11; req_cmd = {11'h602, 11'h601};
    for (int k = 0; k < 12 && gseq.size() < 4; k++) begin
      step();
      if (o_grant != 0) gseq.push_back(o_grant);
    end
    req = '0;
    check("T3 grant count", 32'(gseq.size()), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) begin
`ifdef DISPLAY_SEQ_FIXED_PRIO_EN
      check($sformatf("T3 grant %0d", i), 32'(gseq[i]), 32'h1);
`else
      check($sformatf("T3 grant %0d", i), 32'(gseq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
`endif
    end
    repeat (3) step();

    // T4: stall in S_ISSUE with i_ready low for 20 cycles.
    ready = 1'b0; req = 2'b01; req_cmd = {11'h000, 11'h2C3};
    step();
    check("T4 grant", 32'(o_grant), 32'h1);
    req = '0;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_valid !== 1'b1 || o_command !== 11'h2C3 || o_grant !== 2'b00) stable = 1'b0;
    end
    check("T4 stable while stalled", 32'(stable), 1);
    ready = 1'b1;
    step();
    check("T4 valid after transfer", 32'(o_valid), 0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_valid === 1'b1) cnt++;
    end
    check("T4 single transfer", 32'(cnt), 0);

    // T5: requester issues clear; next word must wait out the hold-off.
    req = 2'b01; req_cmd = {11'h000, 11'h001};
    step();
    check("T5 clear granted", 32'(o_command), 32'h001);
    g = cyc;
    req_cmd = {11'h000, 11'h0AB};
    rise = -1;
    for (int k = 0; k < 100 && rise < 0; k++) begin
      step();
      if (o_valid === 1'b1) rise = cyc;
    end
    check("T5 hold-off >= 50", 32'(rise >= 0 && rise - g >= 50), 1);
    check("T5 next command", 32'(o_command), 32'h0AB);
    req = '0;
    repeat (3) step();

    // T6: reset mid-transfer replays power-up and init.
    ready = 1'b0; req = 2'b10; req_cmd = {11'h345, 11'h000};
    step();
    req = '0;
    step();
    check("T6 valid before reset", 32'(o_valid), 1);
    rst = 1'b1;
    step();
    check("T6 valid after reset", 32'(o_valid), 0);
    check("T6 init_done after reset", 32'(o_init_done), 0);
    rst = 1'b0;
    run_init("T6");

    // Random traffic against the transaction-level model (pointer is back at 0).
    m_valid = 1'b0; m_grant = '0; m_cmd = '0; m_ptr = 0; m_idle_from = cyc;
    for (int n = 0; n < 3000; n++) begin
      check("rnd grant", 32'(o_grant), 32'(m_grant));
      check("rnd valid", 32'(o_valid), 32'(m_valid));
      if (m_valid) check("rnd command", 32'(o_command), 32'(m_cmd));
      for (int k = 0; k < NREQ; k++) begin
        if (m_grant[k]) begin
          req[k] = 1'($urandom_range(0, 1));
          req_cmd[k*W +: W] = rand_cmd();
        end else if (!req[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
          req_cmd[k*W +: W] = rand_cmd();
        end
      end
      ready = ($urandom_range(0, 2) != 0);
      m_grant = '0;
      if (m_valid && ready) begin
        m_valid = 1'b0;
        m_idle_from = cyc + 1 + ((m_cmd == 11'h001 || m_cmd == 11'h002) ? 50 : 0);
      end else if (!m_valid && cyc >= m_idle_from && req != 0) begin
        w = model_pick(req);
        m_grant[w] = 1'b1;
        m_valid = 1'b1;
        m_cmd = req_cmd[w*W +: W];
        m_ptr = (w + 1) % NREQ;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
